// File: rtl/pipeline_stall_ctrl_if.sv
// Control bundle between the hazard/requester side and the pipeline stall controller.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_use;
    logic             branch_taken;
    logic             dmem_busy;
    logic             halt_req;
    logic             resume;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_bubble;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output load_use, branch_taken, dmem_busy, halt_req, resume,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_bubble, halted, mem_timeout,
               stall_cycles, flush_events
    );

    modport slave (
        input  load_use, branch_taken, dmem_busy, halt_req, resume,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_bubble, halted, mem_timeout,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage pipe: per-stage write enables and
// flushes, halt/drain sequencing, MEM-wait watchdog and saturating perf counters.
//
//   state       | meaning
//   ------------+----------------------------------------------------------------
//   ST_RUN      | normal operation, stage controls follow request priority
//   ST_MEM_WAIT | data memory busy; MEM held, a halt request is remembered
//   ST_DRAIN    | fetch stopped, IF/ID loads NOPs until DRAIN_CYC bubbles pass
//   ST_HALTED   | pipe drained and frozen until resume
module pipeline_stall_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int DRAIN_CYC   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_stall_ctrl_if.slave  ctl
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               halt_pend_q, halt_pend_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;

    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, memwb_bubble, halted;

    // State and bookkeeping registers, synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            halt_pend_q   <= 1'b0;
            drain_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
            flush_q       <= '0;
        end else begin
            state_q       <= state_d;
            halt_pend_q   <= halt_pend_d;
            drain_cnt_q   <= drain_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_q       <= stall_d;
            flush_q       <= flush_d;
        end
    end

    // Next-state logic; a halt seen while memory is busy is held until the MEM stage releases.
    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ctl.dmem_busy) begin
                    state_d     = ST_MEM_WAIT;
                    halt_pend_d = ctl.halt_req;
                end else if (ctl.halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (ctl.halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (!ctl.dmem_busy) begin
                    halt_pend_d = 1'b0;
                    drain_cnt_d = '0;
                    state_d     = (halt_pend_q || ctl.halt_req) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!ctl.dmem_busy) begin
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (ctl.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Stage controls, combinational so a request acts in the cycle it is raised.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        halted       = (state_q == ST_HALTED);
        if (state_q == ST_HALTED || ctl.dmem_busy) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            if (ctl.branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (ctl.load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            // Draining never refetches, even on a taken branch.
            if (state_q == ST_DRAIN) begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // Watchdog on consecutive busy cycles and saturating perf counters.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q != ST_HALTED && ctl.dmem_busy) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                              : wait_cnt_q + WAIT_W'(1);
        end
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_W'(MEM_TIMEOUT));

        stall_d = stall_q;
        if (!pc_write && state_q != ST_HALTED && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
        flush_d = flush_q;
        if (ifid_flush && flush_q != {CNT_W{1'b1}}) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    assign ctl.pc_write     = pc_write;
    assign ctl.ifid_write   = ifid_write;
    assign ctl.ifid_flush   = ifid_flush;
    assign ctl.idex_write   = idex_write;
    assign ctl.idex_flush   = idex_flush;
    assign ctl.exmem_write  = exmem_write;
    assign ctl.memwb_bubble = memwb_bubble;
    assign ctl.halted       = halted;
    assign ctl.mem_timeout  = mem_timeout_q;
    assign ctl.stall_cycles = stall_q;
    assign ctl.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vectors, a cycle-level reference model and literal checks.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W       = 3;
    localparam int MEM_TIMEOUT = 4;
    localparam int DRAIN_CYC   = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .DRAIN_CYC   (DRAIN_CYC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: halted flag, bubbles still to inject, owed halt, busy streak, counters.
    bit m_halted;
    int m_bubbles;
    bit m_owed;
    int m_streak;
    bit m_to;
    int m_stall;
    int m_flush;
    bit seen_rst = 1'b0;

    always @(negedge clk) begin
        bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub;
        if (rst) begin
            m_halted = 0; m_bubbles = 0; m_owed = 0; m_streak = 0;
            m_to = 0; m_stall = 0; m_flush = 0;
            seen_rst = 1'b1;
        end else if (seen_rst) begin
            e_pc = 1; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_exw = 1; e_bub = 0;
            if (m_halted || bus.dmem_busy) begin
                e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_bub = 1;
            end else begin
                if (bus.branch_taken) begin
                    e_iff = 1; e_idf = 1;
                end else if (bus.load_use) begin
                    e_pc = 0; e_ifw = 0; e_idf = 1;
                end
                if (m_bubbles > 0) begin
                    e_pc = 0; e_iff = 1;
                end
            end
            chk("pc_write",     bus.pc_write,     e_pc);
            chk("ifid_write",   bus.ifid_write,   e_ifw);
            chk("ifid_flush",   bus.ifid_flush,   e_iff);
            chk("idex_write",   bus.idex_write,   e_idw);
            chk("idex_flush",   bus.idex_flush,   e_idf);
            chk("exmem_write",  bus.exmem_write,  e_exw);
            chk("memwb_bubble", bus.memwb_bubble, e_bub);
            chk("halted",       bus.halted,       m_halted);
            chk("mem_timeout",  bus.mem_timeout,  m_to);
            chk("stall_cycles", bus.stall_cycles, m_stall);
            chk("flush_events", bus.flush_events, m_flush);

            if (!m_halted && !e_pc && m_stall < CMAX) m_stall++;
            if (e_iff && m_flush < CMAX) m_flush++;
            if (!m_halted && bus.dmem_busy) m_streak++;
            else m_streak = 0;
            if (m_streak >= MEM_TIMEOUT) m_to = 1;

            if (m_halted) begin
                if (bus.resume) m_halted = 0;
            end else if (m_bubbles > 0) begin
                if (!bus.dmem_busy) begin
                    m_bubbles--;
                    if (m_bubbles == 0) m_halted = 1;
                end
            end else if (bus.dmem_busy) begin
                if (bus.halt_req) m_owed = 1;
            end else begin
                if (bus.halt_req || m_owed) m_bubbles = DRAIN_CYC;
                m_owed = 0;
            end
        end
    end

    task automatic cyc(input bit lu, input bit br, input bit bz, input bit hr, input bit rs);
        @(posedge clk);
        #1;
        rst              = 1'b0;
        bus.load_use     = lu;
        bus.branch_taken = br;
        bus.dmem_busy    = bz;
        bus.halt_req     = hr;
        bus.resume       = rs;
        @(negedge clk);
        #1;
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        rst              = 1'b1;
        bus.load_use     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.dmem_busy    = 1'b0;
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.load_use = 0; bus.branch_taken = 0; bus.dmem_busy = 0;
        bus.halt_req = 0; bus.resume = 0;
        repeat (2) @(posedge clk);

        cyc(0,0,0,0,0);
        chk("L_rst_pc", bus.pc_write, 1);
        chk("L_rst_stall", bus.stall_cycles, 0);
        chk("L_rst_halted", bus.halted, 0);

        cyc(1,0,0,0,0);
        chk("L_lu_pc", bus.pc_write, 0);
        chk("L_lu_ifidw", bus.ifid_write, 0);
        chk("L_lu_idexf", bus.idex_flush, 1);
        cyc(0,0,0,0,0);
        chk("L_lu_stall", bus.stall_cycles, 1);

        cyc(1,1,0,0,0);
        chk("L_brlu_pc", bus.pc_write, 1);
        chk("L_brlu_iff", bus.ifid_flush, 1);
        chk("L_brlu_idf", bus.idex_flush, 1);
        cyc(0,0,0,0,0);
        chk("L_brlu_flush", bus.flush_events, 1);
        chk("L_brlu_stall", bus.stall_cycles, 1);

        for (int i = 0; i < 3; i++) begin
            cyc(0,1,1,0,0);
            chk("L_busy_bub", bus.memwb_bubble, 1);
            chk("L_busy_iff", bus.ifid_flush, 0);
        end
        cyc(0,1,0,0,0);
        chk("L_rel_iff", bus.ifid_flush, 1);
        chk("L_rel_pc", bus.pc_write, 1);
        cyc(0,0,0,0,0);
        chk("L_rel_stall", bus.stall_cycles, 4);
        chk("L_rel_flush", bus.flush_events, 2);

        for (int i = 1; i <= 6; i++) begin
            cyc(0,0,1,0,0);
            chk("L_to_flag", bus.mem_timeout, (i >= 5) ? 1 : 0);
        end
        cyc(0,0,0,0,0);
        chk("L_to_sticky", bus.mem_timeout, 1);
        chk("L_to_stall_sat", bus.stall_cycles, 7);
        rst_cyc();
        cyc(0,0,0,0,0);
        chk("L_to_clr", bus.mem_timeout, 0);

        cyc(0,0,0,1,0);
        chk("L_hr_pc", bus.pc_write, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0,0,0,0,0);
            chk("L_drain_halted", bus.halted, 0);
            chk("L_drain_iff", bus.ifid_flush, 1);
        end
        cyc(0,0,0,0,0);
        chk("L_halted", bus.halted, 1);
        chk("L_halted_bub", bus.memwb_bubble, 1);
        cyc(0,0,0,0,1);
        chk("L_resume_cyc", bus.halted, 1);
        cyc(0,0,0,0,0);
        chk("L_resumed", bus.halted, 0);
        chk("L_resumed_pc", bus.pc_write, 1);
        chk("L_halt_stall", bus.stall_cycles, 4);
        chk("L_halt_flush", bus.flush_events, 4);

        rst_cyc();
        repeat (9) cyc(1,0,0,0,0);
        cyc(0,0,0,0,0);
        chk("L_sat7", bus.stall_cycles, 7);

        cyc(0,0,0,1,0);
        cyc(0,0,0,0,0);
        cyc(0,0,0,0,0);
        rst_cyc();
        cyc(0,0,0,0,0);
        chk("L_rstdr_pc", bus.pc_write, 1);
        chk("L_rstdr_stall", bus.stall_cycles, 0);
        chk("L_rstdr_flush", bus.flush_events, 0);
        repeat (6) cyc(0,0,0,0,0);
        chk("L_no_resid", bus.halted, 0);

        cyc(0,0,1,1,0);
        cyc(0,0,1,0,0);
        cyc(0,0,0,0,0);
        cyc(0,1,0,0,0);
        chk("L_drain_br_pc", bus.pc_write, 0);
        cyc(0,0,1,0,0);
        cyc(1,0,0,0,0);
        cyc(0,0,0,0,0);
        cyc(0,0,0,0,0);
        cyc(0,0,0,1,0);
        chk("L_latched_halt", bus.halted, 1);
        cyc(0,0,0,0,1);
        cyc(0,0,0,0,1);
        cyc(1,1,0,0,0);
        cyc(0,0,1,0,0);
        cyc(0,1,0,0,0);
        cyc(0,0,0,0,0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
